// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 types, constants and helpers shared by the host transmitter
// (ps2_host_tx) and the keyboard receive path.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SHIFT,
      ACK,
      RECOVER
   } ps2_state_t;

   // Cycles the data line is pulled low under an inhibited clock
   localparam int RTS_CYCLES = 16;

   // Data bits, parity and stop bit; the start bit is presented separately
   localparam int FRAME_LEN  = 10;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer plus falling-edge detector for a PS/2 pin.
// Ports: CLK_CPU, reset (sync, active-high), pin (raw), level (synced), fall (1-cycle).
module ps2_sync_edge (
   input  logic CLK_CPU,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic fall
);

   // [0],[1] synchronize; [2] holds the previous synced level.
   // Reset to 1 (idle bus level) so no spurious fall follows reset.
   logic [2:0] sh_q;

   always_ff @(posedge CLK_CPU) begin
      if (reset) begin
         sh_q <= 3'b111;
      end else begin
         sh_q <= {sh_q[1:0], pin};
      end
   end

   assign level = sh_q[1];
   assign fall  = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, RTS, 10-bit
// frame on device clock falls, ACK sample, wait for idle lines).
// Ports: CLK_CPU, reset; tx_valid/tx_data/tx_ready accept side;
// ps2_clk_in/ps2_data_in raw pins; ps2_clk_oe/ps2_data_oe pull-low enables;
// busy, done (1-cycle pulse), err (NACK or timeout, valid with done).
// Build option: define PS2_TX_TIMEOUT_EN to add start and packet timeouts.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ_HZ      = 16000000,
   parameter int INHIBIT_US       = 100,
   parameter int START_TIMEOUT_US = 15000,
   parameter int PKT_TIMEOUT_US   = 2000
) (
   input  logic       CLK_CPU,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int CYC_PER_US     = CLK_FREQ_HZ / 1000000;
   localparam int INHIBIT_CYCLES = CYC_PER_US * INHIBIT_US;
   localparam int CNT_MAX        = (INHIBIT_CYCLES > RTS_CYCLES) ?
                                   INHIBIT_CYCLES : RTS_CYCLES;
   localparam int CNT_W          = $clog2(CNT_MAX) + 1;

   ps2_state_t           state_q, state_d;
   logic [FRAME_LEN-1:0] frame_q, frame_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 nack_q, nack_d;
   logic                 clk_oe_q, clk_oe_d;
   logic                 data_oe_q, data_oe_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic clk_sync, clk_fall;
   logic data_sync, data_fall_unused;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int START_CYCLES = CYC_PER_US * START_TIMEOUT_US;
   localparam int PKT_CYCLES   = CYC_PER_US * PKT_TIMEOUT_US;
   localparam int TMO_MAX      = (START_CYCLES > PKT_CYCLES) ?
                                 START_CYCLES : PKT_CYCLES;
   localparam int TMO_W        = $clog2(TMO_MAX) + 1;

   // One counter serves both timeouts: it restarts on leaving RTS
   // (start wait) and again on the first device fall (packet).
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             start_exp, pkt_exp, abort;

   assign start_exp = (tmo_q == TMO_W'(START_CYCLES - 1));
   assign pkt_exp   = (tmo_q == TMO_W'(PKT_CYCLES - 1));
`else
   // No timeout hardware in this build; only reset leaves a stuck transfer.
   localparam int TMO_CFG_UNUSED = START_TIMEOUT_US + PKT_TIMEOUT_US;
`endif

   ps2_sync_edge u_clk_sync (
      .CLK_CPU (CLK_CPU),
      .reset   (reset),
      .pin     (ps2_clk_in),
      .level   (clk_sync),
      .fall    (clk_fall)
   );

   ps2_sync_edge u_data_sync (
      .CLK_CPU (CLK_CPU),
      .reset   (reset),
      .pin     (ps2_data_in),
      .level   (data_sync),
      .fall    (data_fall_unused)
   );

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      nack_d    = nack_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      tmo_d     = tmo_q + TMO_W'(1);
      abort     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx_valid) begin
               state_d  = INHIBIT;
               frame_d  = {1'b1, odd_parity(tx_data), tx_data};
               cnt_d    = '0;
               clk_oe_d = 1'b1;
            end
         end
         INHIBIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
               state_d   = RTS;
               cnt_d     = '0;
               data_oe_d = 1'b1;
            end
         end
         RTS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(RTS_CYCLES - 1)) begin
               // Releasing the clock with data held low is the start bit
               state_d   = SHIFT;
               clk_oe_d  = 1'b0;
               bit_cnt_d = '0;
`ifdef PS2_TX_TIMEOUT_EN
               tmo_d     = '0;
`endif
            end
         end
         SHIFT: begin
            if (clk_fall) begin
               data_oe_d = ~frame_q[0];
               frame_d   = {1'b0, frame_q[FRAME_LEN-1:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'(FRAME_LEN - 1)) begin
                  state_d = ACK;
               end
`ifdef PS2_TX_TIMEOUT_EN
               if (bit_cnt_q == 4'd0) begin
                  tmo_d = '0;
               end
`endif
            end
`ifdef PS2_TX_TIMEOUT_EN
            else if ((bit_cnt_q == 4'd0) ? start_exp : pkt_exp) begin
               abort = 1'b1;
            end
`endif
         end
         ACK: begin
            if (clk_fall) begin
               nack_d  = data_sync;
               state_d = RECOVER;
            end
`ifdef PS2_TX_TIMEOUT_EN
            else if (pkt_exp) begin
               abort = 1'b1;
            end
`endif
         end
         RECOVER: begin
            if (clk_sync && data_sync) begin
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = nack_q;
            end
         end
         default: begin
            state_d   = IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
         end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      if (abort) begin
         state_d   = IDLE;
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         done_d    = 1'b1;
         err_d     = 1'b1;
      end
`endif
   end

   always_ff @(posedge CLK_CPU) begin
      if (reset) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         bit_cnt_q <= '0;
         cnt_q     <= '0;
         nack_q    <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
         nack_q    <= nack_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign tx_ready    = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule
